// File: rtl/pong_ball_if.sv
// Pong ball engine bus: paddle positions and start in, ball position, scores and events out.
interface pong_ball_if;
  logic       start;
  logic [8:0] pad_l_y;
  logic [8:0] pad_r_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       point_l;
  logic       point_r;
  logic       game_over;

  modport master (
    output start, pad_l_y, pad_r_y,
    input  ball_x, ball_y, score_l, score_r, point_l, point_r, game_over
  );

  modport slave (
    input  start, pad_l_y, pad_r_y,
    output ball_x, ball_y, score_l, score_r, point_l, point_r, game_over
  );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong ball engine: tick-paced ball motion, wall/paddle bounces, miss detection,
// scoring and the idle/serve/play/score/game-over sequence.
module pong_ball_ctrl #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL        = 8,
  parameter int unsigned PAD_H       = 75,
  parameter int unsigned PAD_W       = 8,
  parameter int unsigned PADL_X      = 16,
  parameter int unsigned PADR_X      = 616,
  parameter int unsigned STEP        = 2,
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned SERVE_TICKS = 100,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic        clk,
  input  logic        reset,
  pong_ball_if.slave  bus
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SRV_W = $clog2(SERVE_TICKS + 1);

  // 11-bit geometry so edge sums never wrap
  localparam logic [10:0] XC_W    = 11'(SCREEN_W / 2 - BALL / 2);
  localparam logic [10:0] YC_W    = 11'(SCREEN_H / 2 - BALL / 2);
  localparam logic [10:0] W_W     = 11'(SCREEN_W);
  localparam logic [10:0] H_W     = 11'(SCREEN_H);
  localparam logic [10:0] BALL_W  = 11'(BALL);
  localparam logic [10:0] PADH_W  = 11'(PAD_H);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] LFACE_W = 11'(PADL_X + PAD_W);
  localparam logic [10:0] RFACE_W = 11'(PADR_X);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORE, GAME_OVER} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [SRV_W-1:0] srv_cnt;
  logic [9:0]       ball_x;
  logic [8:0]       ball_y;
  logic [3:0]       score_l;
  logic [3:0]       score_r;
  logic             point_l;
  logic             point_r;
  logic             game_over;
  logic             dx_right;
  logic             dy_down;
  logic             scorer_l;

  logic        tick;
  logic [10:0] x_w, y_w, pl_w, pr_w, nx, ny;
  logic        ndx, ndy, ov_l, ov_r, hit_l, hit_r;
  logic [3:0]  score_nx;

  assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign x_w      = {1'b0, ball_x};
  assign y_w      = {2'b0, ball_y};
  assign pl_w     = {2'b0, bus.pad_l_y};
  assign pr_w     = {2'b0, bus.pad_r_y};
  assign ov_l     = (y_w + BALL_W > pl_w) && (y_w < pl_w + PADH_W);
  assign ov_r     = (y_w + BALL_W > pr_w) && (y_w < pr_w + PADH_W);
  assign score_nx = scorer_l ? (score_l + 4'd1) : (score_r + 4'd1);

  // Next position from pre-update values; hit_l/hit_r flag a point for that player
  always_comb begin
    ny    = y_w;
    ndy   = dy_down;
    nx    = x_w;
    ndx   = dx_right;
    hit_l = 1'b0;
    hit_r = 1'b0;
    if (dy_down) begin
      if (y_w + BALL_W + STEP_W > H_W) begin
        ny  = H_W - BALL_W;
        ndy = 1'b0;
      end else begin
        ny = y_w + STEP_W;
      end
    end else begin
      if (y_w < STEP_W) begin
        ny  = 11'd0;
        ndy = 1'b1;
      end else begin
        ny = y_w - STEP_W;
      end
    end
    if (!dx_right) begin
      if (x_w >= LFACE_W && x_w < LFACE_W + STEP_W && ov_l) begin
        nx  = LFACE_W;
        ndx = 1'b1;
      end else if (x_w < STEP_W) begin
        hit_r = 1'b1;
      end else begin
        nx = x_w - STEP_W;
      end
    end else begin
      if (x_w + BALL_W <= RFACE_W && x_w + BALL_W + STEP_W > RFACE_W && ov_r) begin
        nx  = RFACE_W - BALL_W;
        ndx = 1'b0;
      end else if (x_w + BALL_W + STEP_W > W_W) begin
        hit_l = 1'b1;
      end else begin
        nx = x_w + STEP_W;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      srv_cnt   <= '0;
      ball_x    <= 10'(XC_W);
      ball_y    <= 9'(YC_W);
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      point_l   <= 1'b0;
      point_r   <= 1'b0;
      game_over <= 1'b0;
      dx_right  <= 1'b1;
      dy_down   <= 1'b1;
      scorer_l  <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      point_l  <= 1'b0;
      point_r  <= 1'b0;
      case (state)
        IDLE: begin
          ball_x <= 10'(XC_W);
          ball_y <= 9'(YC_W);
          if (bus.start) begin
            state   <= SERVE;
            score_l <= 4'd0;
            score_r <= 4'd0;
            srv_cnt <= '0;
          end
        end
        SERVE: begin
          ball_x  <= 10'(XC_W);
          ball_y  <= 9'(YC_W);
          dy_down <= 1'b1;
          if (tick) begin
            if (srv_cnt == SRV_W'(SERVE_TICKS - 1)) state <= PLAY;
            else srv_cnt <= srv_cnt + SRV_W'(1);
          end
        end
        PLAY: begin
          if (tick) begin
            ball_y  <= 9'(ny);
            dy_down <= ndy;
            if (hit_l || hit_r) begin
              state    <= SCORE;
              scorer_l <= hit_l;
            end else begin
              ball_x   <= 10'(nx);
              dx_right <= ndx;
            end
          end
        end
        SCORE: begin
          ball_x <= 10'(XC_W);
          ball_y <= 9'(YC_W);
          if (scorer_l) begin
            score_l  <= score_nx;
            point_l  <= 1'b1;
            dx_right <= 1'b1;
          end else begin
            score_r  <= score_nx;
            point_r  <= 1'b1;
            dx_right <= 1'b0;
          end
          if (score_nx == 4'(WIN_SCORE)) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
          end else begin
            state   <= SERVE;
            srv_cnt <= '0;
          end
        end
        GAME_OVER: begin
          ball_x <= 10'(XC_W);
          ball_y <= 9'(YC_W);
          if (bus.start) begin
            state     <= SERVE;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
            srv_cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ball_x    = ball_x;
  assign bus.ball_y    = ball_y;
  assign bus.score_l   = score_l;
  assign bus.score_r   = score_r;
  assign bus.point_l   = point_l;
  assign bus.point_r   = point_r;
  assign bus.game_over = game_over;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl: serve timing, wall and paddle bounces, misses,
// scoring, game over and asynchronous reset, with hand-computed ball coordinates.
module tb_pong_ball_ctrl;

  localparam int unsigned TDIV = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   tcnt;

  pong_ball_if bus1 ();
  pong_ball_if bus2 ();

  pong_ball_ctrl #(.TICK_DIV(TDIV), .SERVE_TICKS(3), .WIN_SCORE(9)) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  pong_ball_ctrl #(.TICK_DIV(TDIV), .SERVE_TICKS(3), .WIN_SCORE(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running tick phase: the edge after tcnt==TDIV-1 is a move tick
  always @(posedge clk or posedge reset) begin
    if (reset) tcnt <= 0;
    else tcnt <= (tcnt == int'(TDIV) - 1) ? 0 : tcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance through n move-tick edges, leaving time #1 after the last one
  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      while (tcnt != int'(TDIV) - 1) step();
      step();
    end
  endtask

  task automatic chk_ball1(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(bus1.ball_x), 32'(x));
    chk({tag, "_y"}, 32'(bus1.ball_y), 32'(y));
  endtask

  task automatic chk_ball2(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(bus2.ball_x), 32'(x));
    chk({tag, "_y"}, 32'(bus2.ball_y), 32'(y));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus1.start = 1'b0; bus1.pad_l_y = 9'd0; bus1.pad_r_y = 9'd0;
    bus2.start = 1'b0; bus2.pad_l_y = 9'd0; bus2.pad_r_y = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_ball1("rst_ball", 316, 236);
    chk("rst_score_l", 32'(bus1.score_l), 32'd0);
    chk("rst_score_r", 32'(bus1.score_r), 32'd0);
    chk("rst_point", 32'({bus1.point_l, bus1.point_r}), 32'd0);
    chk("rst_game_over", 32'(bus1.game_over), 32'd0);
    reset = 1'b0;
    do_tick(5);
    chk_ball1("idle_hold", 316, 236);

    // Serve: three resting ticks, then first diagonal move
    bus1.start = 1'b1; step(); bus1.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_tick(1);
      chk_ball1("serve_hold", 316, 236);
    end
    do_tick(1);
    chk_ball1("first_move", 318, 238);

    // Bottom wall bounce
    do_tick(117);
    chk_ball1("pre_bottom", 552, 472);
    do_tick(1);
    chk_ball1("bottom_clamp", 554, 472);
    do_tick(1);
    chk_ball1("bottom_up", 556, 470);

    // Right paddle hit
    bus1.pad_r_y = 9'd380;
    do_tick(26);
    chk_ball1("pre_rhit", 608, 418);
    do_tick(1);
    chk_ball1("rhit", 608, 416);
    chk("rhit_point", 32'({bus1.point_l, bus1.point_r}), 32'd0);
    do_tick(1);
    chk_ball1("rhit_left", 606, 414);

    // Top wall bounce on the way left, left paddle at 0 misses, right player scores
    do_tick(304);
    chk_ball1("lmiss_pre", 0, 192);
    chk("lmiss_pre_point", 32'(bus1.point_r), 32'd0);
    step();
    chk("lmiss_point_r", 32'(bus1.point_r), 32'd1);
    chk("lmiss_score_r", 32'(bus1.score_r), 32'd1);
    chk_ball1("lmiss_centre", 316, 236);
    step();
    chk("lmiss_pulse_end", 32'(bus1.point_r), 32'd0);

    // Serves toward the conceding left player keep missing on the left
    for (int p = 2; p <= 3; p++) begin
      do_tick(162);
      chk_ball1("lserve_miss", 0, 392);
      step();
      chk("lserve_score_r", 32'(bus1.score_r), 32'(p));
      chk("lserve_point_r", 32'(bus1.point_r), 32'd1);
    end

    // Asynchronous reset mid-play
    do_tick(45);
    chk_ball1("mid_play", 232, 320);
    reset = 1'b1;
    #1;
    chk_ball1("async_rst_ball", 316, 236);
    chk("async_rst_score_r", 32'(bus1.score_r), 32'd0);
    chk("async_rst_score_l", 32'(bus1.score_l), 32'd0);
    step(); step();
    reset = 1'b0;
    do_tick(10);
    chk_ball1("post_rst_idle", 316, 236);

    // Right paddle miss, left player scores, serve goes right toward the conceder
    bus1.pad_r_y = 9'd0;
    bus1.start = 1'b1; step(); bus1.start = 1'b0;
    do_tick(161);
    chk_ball1("rmiss_edge", 632, 394);
    do_tick(1);
    chk_ball1("rmiss_tick", 632, 392);
    chk("rmiss_pre_point", 32'(bus1.point_l), 32'd0);
    step();
    chk("rmiss_point_l", 32'(bus1.point_l), 32'd1);
    chk("rmiss_score_l", 32'(bus1.score_l), 32'd1);
    chk("rmiss_score_r", 32'(bus1.score_r), 32'd0);
    chk_ball1("rmiss_centre", 316, 236);
    step();
    chk("rmiss_pulse_end", 32'(bus1.point_l), 32'd0);
    do_tick(3);
    chk_ball1("reserve_hold", 316, 236);
    do_tick(1);
    chk_ball1("reserve_move", 318, 238);

    // Game over at WIN_SCORE=2 on the second instance
    bus2.start = 1'b1; step(); bus2.start = 1'b0;
    do_tick(162);
    chk_ball2("g_miss1", 632, 392);
    step();
    chk("g_score1", 32'(bus2.score_l), 32'd1);
    chk("g_go0", 32'(bus2.game_over), 32'd0);
    do_tick(162);
    step();
    chk("g_score2", 32'(bus2.score_l), 32'd2);
    chk("g_point2", 32'(bus2.point_l), 32'd1);
    chk("g_go1", 32'(bus2.game_over), 32'd1);
    do_tick(50);
    chk_ball2("g_hold", 316, 236);
    chk("g_go_hold", 32'(bus2.game_over), 32'd1);
    chk("g_score_frozen", 32'(bus2.score_l), 32'd2);
    bus2.start = 1'b1; step(); bus2.start = 1'b0;
    chk("g_restart_go", 32'(bus2.game_over), 32'd0);
    chk("g_restart_score_l", 32'(bus2.score_l), 32'd0);
    chk("g_restart_score_r", 32'(bus2.score_r), 32'd0);
    do_tick(3);
    chk_ball2("g_restart_serve", 316, 236);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
